// File: rtl/spart_driver_if.sv
// SPART register-bus control signals between the bus master (spart_driver) and the SPART.
// The bidirectional databus is kept as a plain inout so its tristate resolves at the top level.
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (
      output iocs,
      output iorw,
      output ioaddr,
      input  rda,
      input  tbr
   );

   modport slave (
      input  iocs,
      input  iorw,
      input  ioaddr,
      output rda,
      output tbr
   );
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: loads the baud divisor selected by br_cfg, then echoes every received
// byte back to the transmit buffer. All bus outputs are decoded from registered state.
module spart_driver #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter logic [15:0] DIV_4800  = 16'd650,
   parameter logic [15:0] DIV_9600  = 16'd325,
   parameter logic [15:0] DIV_19200 = 16'd162,
   parameter logic [15:0] DIV_38400 = 16'd80
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    br_cfg,
   spart_driver_if.master bus,
   inout  wire  [7:0]    databus,
   output logic [7:0]    last_rx,
   output logic [7:0]    echo_cnt
);

   typedef enum logic [2:0] {
      StInitLo,
      StInitHi,
      StIdle,
      StRead,
      StWaitTbr,
      StWrite
   } state_e;

   state_e      state_q, state_d;
   logic        active_q;
   logic [1:0]  br_meta_q, br_sync_q;
   logic [1:0]  cfg_q;
   logic        cfg_pending_q, cfg_pending_d;
   logic [7:0]  rx_byte_q;
   logic [7:0]  echo_cnt_q;
   logic [15:0] div;

   logic        iocs_c;
   logic        iorw_c;
   logic [1:0]  ioaddr_c;
   logic [7:0]  wdata;
   logic        drive_en;

   // The divisor table is fixed for a 50 MHz clock; CLK_FREQ is informational only.
   logic unused_clk_freq;
   assign unused_clk_freq = ^CLK_FREQ;

   always_comb begin
      unique case (cfg_q)
         2'b00:   div = DIV_4800;
         2'b01:   div = DIV_9600;
         2'b10:   div = DIV_19200;
         default: div = DIV_38400;
      endcase
   end

   always_ff @(posedge clk) begin
      br_meta_q <= br_cfg;
      br_sync_q <= br_meta_q;
      if (rst) begin
         state_q       <= StInitLo;
         active_q      <= 1'b0;
         cfg_q         <= br_sync_q;
         cfg_pending_q <= 1'b0;
         rx_byte_q     <= 8'h00;
         echo_cnt_q    <= 8'h00;
      end else begin
         state_q       <= state_d;
         active_q      <= 1'b1;
         cfg_q         <= br_sync_q;
         cfg_pending_q <= cfg_pending_d;
         if (active_q && state_q == StRead) begin
            rx_byte_q <= databus;
         end
         if (active_q && state_q == StWrite) begin
            echo_cnt_q <= echo_cnt_q + 8'd1;
         end
      end
   end

   // First cycle out of reset holds INIT_LO so its write is presented for a full cycle.
   always_comb begin
      state_d       = state_q;
      cfg_pending_d = cfg_pending_q;
      if (br_sync_q != cfg_q) begin
         cfg_pending_d = 1'b1;
      end
      if (!active_q) begin
         state_d = StInitLo;
      end else begin
         unique case (state_q)
            StInitLo:  state_d = StInitHi;
            StInitHi:  state_d = StIdle;
            StIdle: begin
               if (cfg_pending_q) begin
                  // cfg_q is reloaded on this same edge, so a coincident change is covered too.
                  state_d       = StInitLo;
                  cfg_pending_d = 1'b0;
               end else if (bus.rda) begin
                  state_d = StRead;
               end
            end
            StRead:    state_d = StWaitTbr;
            StWaitTbr: if (bus.tbr) state_d = StWrite;
            StWrite:   state_d = StIdle;
            default:   state_d = StInitLo;
         endcase
      end
   end

   always_comb begin
      iocs_c   = 1'b0;
      iorw_c   = 1'b1;
      ioaddr_c = 2'b00;
      wdata    = 8'h00;
      if (active_q) begin
         unique case (state_q)
            StInitLo: begin
               iocs_c   = 1'b1;
               iorw_c   = 1'b0;
               ioaddr_c = 2'b10;
               wdata    = div[7:0];
            end
            StInitHi: begin
               iocs_c   = 1'b1;
               iorw_c   = 1'b0;
               ioaddr_c = 2'b11;
               wdata    = div[15:8];
            end
            StRead: begin
               iocs_c = 1'b1;
            end
            StWrite: begin
               iocs_c = 1'b1;
               iorw_c = 1'b0;
               wdata  = rx_byte_q;
            end
            default: ;
         endcase
      end
   end

   assign drive_en   = iocs_c & ~iorw_c;
   assign databus    = drive_en ? wdata : 8'hzz;
   assign bus.iocs   = iocs_c;
   assign bus.iorw   = iorw_c;
   assign bus.ioaddr = ioaddr_c;
   assign last_rx    = rx_byte_q;
   assign echo_cnt   = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a SPART responder, a bus-access scoreboard and a transaction-level
// model of reload/echo ordering, driven by directed cases and a randomized action loop.
module tb_spart_driver;

   typedef struct packed {
      logic       rw;
      logic [1:0] addr;
      logic [7:0] data;
   } acc_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] br_cfg = 2'b11;
   logic       tb_drive = 1'b0;
   logic [7:0] tb_data = 8'h00;
   wire  [7:0] databus;
   logic [7:0] last_rx;
   logic [7:0] echo_cnt;

   spart_driver_if bus ();

   assign databus = tb_drive ? tb_data : 8'hzz;

   spart_driver dut (
      .clk      (clk),
      .rst      (rst),
      .br_cfg   (br_cfg),
      .bus      (bus),
      .databus  (databus),
      .last_rx  (last_rx),
      .echo_cnt (echo_cnt)
   );

   always #5 clk = ~clk;

   acc_t       exp_q[$];
   logic [7:0] rx_q[$];
   acc_t       mon_e;
   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_reads = 0;
   int n_writes = 0;
   int last_read_cyc = 0;
   int last_write_cyc = 0;
   int last_lo_cyc = 0;
   int last_hi_cyc = 0;
   int model_cnt = 0;
   int model_last = 0;
   logic [1:0] cur_cfg;

   function automatic logic [15:0] div_of(input logic [1:0] c);
      case (c)
         2'd0:    return 16'd650;
         2'd1:    return 16'd325;
         2'd2:    return 16'd162;
         default: return 16'd80;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_init(input logic [1:0] c);
      logic [15:0] d;
      d = div_of(c);
      exp_q.push_back('{rw: 1'b0, addr: 2'b10, data: d[7:0]});
      exp_q.push_back('{rw: 1'b0, addr: 2'b11, data: d[15:8]});
   endtask

   task automatic push_echo(input logic [7:0] b);
      rx_q.push_back(b);
      exp_q.push_back('{rw: 1'b1, addr: 2'b00, data: 8'h00});
      exp_q.push_back('{rw: 1'b0, addr: 2'b00, data: b});
      model_cnt  = (model_cnt + 1) % 256;
      model_last = int'(b);
   endtask

   task automatic model_reset();
      model_cnt  = 0;
      model_last = 0;
   endtask

   task automatic wait_idle(input int bound);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < bound) begin
         tick(1);
         t++;
      end
      check("drain", exp_q.size(), 0);
      exp_q.delete();
      tick(6);
   endtask

   task automatic wait_read();
      int n0;
      int t;
      n0 = n_reads;
      t  = 0;
      while (n_reads == n0 && t < 50) begin
         tick(1);
         t++;
      end
      check("read_seen", int'(n_reads != n0), 1);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_echo_cnt"}, int'(echo_cnt), model_cnt);
      check({tag, "_last_rx"}, int'(last_rx), model_last);
   endtask

   // SPART responder: raises rda while bytes wait, and drives the byte during a read access.
   initial begin
      bus.rda = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) begin
            if (rx_q.size() > 0) tb_data = rx_q.pop_front();
            else tb_data = 8'hEE;
            tb_drive = 1'b1;
         end else begin
            tb_drive = 1'b0;
         end
         bus.rda = (rx_q.size() > 0);
      end
   end

   // Monitor: every bus access is matched in order against the expected-access queue.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.iocs) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_access: got rw=%0b addr=%0d data=0x%0h, expected none",
                        bus.iorw, bus.ioaddr, databus);
            end else begin
               mon_e = exp_q.pop_front();
               check("acc_rw", int'(bus.iorw), int'(mon_e.rw));
               check("acc_addr", int'(bus.ioaddr), int'(mon_e.addr));
               if (!mon_e.rw) check("acc_data", int'(databus), int'(mon_e.data));
            end
            if (bus.iorw) begin
               n_reads++;
               last_read_cyc = cyc;
            end else if (bus.ioaddr == 2'b00) begin
               n_writes++;
               last_write_cyc = cyc;
            end else if (bus.ioaddr == 2'b10) begin
               last_lo_cyc = cyc;
            end else begin
               last_hi_cyc = cyc;
            end
         end else begin
            check("idle_rw_addr", int'({bus.iorw, bus.ioaddr}), 4);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel;
      int raise;
      int w0;
      int found;
      logic [1:0] v1;
      logic [1:0] v2;

      bus.tbr = 1'b1;

      // Reset with br_cfg=11, then check release timing of the divisor writes.
      rst = 1'b1;
      br_cfg = 2'b11;
      cur_cfg = 2'b11;
      tick(4);
      check("rst_iocs", int'(bus.iocs), 0);
      check("rst_iorw", int'(bus.iorw), 1);
      check_model("rst");
      model_reset();
      push_init(2'b11);
      rel = cyc;
      rst = 1'b0;
      wait_idle(50);
      check("init_lo_time", last_lo_cyc - rel, 2);
      check("init_hi_time", last_hi_cyc - rel, 3);

      // br_cfg=01 at reset, then a single reload after switching to 10 while idle.
      rst = 1'b1;
      tick(1);
      br_cfg = 2'b01;
      cur_cfg = 2'b01;
      tick(4);
      model_reset();
      push_init(2'b01);
      rst = 1'b0;
      wait_idle(50);
      br_cfg = 2'b10;
      cur_cfg = 2'b10;
      push_init(2'b10);
      wait_idle(50);

      // Minimum-latency echo of 0x88.
      push_echo(8'h88);
      wait_idle(50);
      check("echo_gap", last_write_cyc - last_read_cyc, 2);
      check_model("echo88");

      // tbr held low for 20 cycles after the read.
      bus.tbr = 1'b0;
      push_echo(8'($urandom_range(0, 255)));
      wait_read();
      w0 = n_writes;
      tick(20);
      check("hold_no_write", n_writes - w0, 0);
      raise = cyc;
      bus.tbr = 1'b1;
      wait_idle(50);
      check("tbr_to_write", last_write_cyc - raise, 2);
      check_model("tbr_hold");

      // br_cfg 11 -> 00 while waiting for tbr: echo completes, then one reload.
      br_cfg = 2'b11;
      cur_cfg = 2'b11;
      push_init(2'b11);
      wait_idle(50);
      bus.tbr = 1'b0;
      push_echo(8'h5C);
      wait_read();
      br_cfg = 2'b00;
      cur_cfg = 2'b00;
      push_init(2'b00);
      tick(8);
      bus.tbr = 1'b1;
      wait_idle(50);
      check_model("cfg_in_wait");

      // Reset asserted during the WRITE cycle.
      bus.tbr = 1'b0;
      push_echo(8'hA7);
      wait_read();
      tick(2);
      bus.tbr = 1'b1;
      found = 0;
      for (int t = 0; t < 20 && found == 0; t++) begin
         @(negedge clk);
         if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) found = 1;
      end
      check("write_seen", found, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midwr_iocs", int'(bus.iocs), 0);
      check("midwr_iorw", int'(bus.iorw), 1);
      model_reset();
      check_model("midwr");
      tick(1);
      push_init(cur_cfg);
      rst = 1'b0;
      wait_idle(50);

      // rda raised during reset/INIT is serviced after the divisor load.
      rst = 1'b1;
      tick(2);
      model_reset();
      push_init(cur_cfg);
      push_echo(8'h3C);
      rst = 1'b0;
      wait_idle(50);
      check_model("rda_in_init");

      // echo_cnt wraps after 256 echoes.
      rst = 1'b1;
      tick(2);
      model_reset();
      push_init(cur_cfg);
      rst = 1'b0;
      wait_idle(50);
      for (int i = 0; i < 255; i++) push_echo(8'($urandom_range(0, 255)));
      wait_idle(3000);
      check("cnt_255", int'(echo_cnt), 255);
      push_echo(8'($urandom_range(0, 255)));
      wait_idle(50);
      check("cnt_wrap", int'(echo_cnt), 0);
      check_model("wrap");

      // Randomized actions against the transaction model.
      for (int it = 0; it < 40; it++) begin
         int act;
         int d;
         act = $urandom_range(0, 3);
         bus.tbr = 1'b1;
         case (act)
            0: begin
               d = $urandom_range(0, 5);
               if (d > 0) bus.tbr = 1'b0;
               push_echo(8'($urandom_range(0, 255)));
               if (d > 0) begin
                  wait_read();
                  tick(d);
                  bus.tbr = 1'b1;
               end
               wait_idle(60);
            end
            1: begin
               v1 = cur_cfg ^ 2'($urandom_range(1, 3));
               br_cfg = v1;
               cur_cfg = v1;
               push_init(v1);
               wait_idle(60);
            end
            2: begin
               bus.tbr = 1'b0;
               push_echo(8'($urandom_range(0, 255)));
               wait_read();
               v1 = cur_cfg ^ 2'($urandom_range(1, 3));
               br_cfg = v1;
               tick(4);
               v2 = v1 ^ 2'($urandom_range(1, 3));
               br_cfg = v2;
               cur_cfg = v2;
               push_init(v2);
               tick(6);
               bus.tbr = 1'b1;
               wait_idle(60);
            end
            default: begin
               rst = 1'b1;
               tick(1);
               v1 = 2'($urandom_range(0, 3));
               br_cfg = v1;
               cur_cfg = v1;
               tick(4);
               model_reset();
               push_init(v1);
               if ($urandom_range(0, 1) == 1) push_echo(8'($urandom_range(0, 255)));
               rst = 1'b0;
               wait_idle(60);
            end
         endcase
         check_model("rand");
      end

      check("leftover_rx", rx_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-side controller for the SPART. Programs the baud-rate divisor from the board switches, then sequences the echo loop: read each received byte over the SPART bus and write it back to the transmit buffer.
- Sits inside lab1_spart between SW[9:8] / LED/HEX display logic and the spart instance.
- Sole master of the SPART register bus: iocs, iorw, ioaddr and the bidirectional databus.

Parameters:
CLK_FREQ, 50000000, system clock in Hz; documentation only, because the divisor table below is fixed for 50 MHz with 16x oversampling.
DIV_4800, 16'd650, divisor for br_cfg=00.
DIV_9600, 16'd325, divisor for br_cfg=01.
DIV_19200, 16'd162, divisor for br_cfg=10.
DIV_38400, 16'd80, divisor for br_cfg=11.

Ports:
clk  input  1  system clock (CLOCK_50); single clock domain.
rst  input  1  synchronous, active-high reset.
br_cfg  input  2  baud select from SW[9:8]; asynchronous to clk, so it passes through a 2-flop synchronizer inside the block.
rda  input  1  SPART receive data available.
tbr  input  1  SPART transmit buffer ready.
iocs  output  1  SPART chip select, asserted for exactly one cycle per bus access.
iorw  output  1  1 = read, 0 = write.
ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
databus  inout  8  driven by this block only when iocs=1 and iorw=0; otherwise high-Z.
last_rx  output  8  most recent byte read from the SPART, for the HEX display.
echo_cnt  output  8  number of completed echoes, wraps 255 -> 0.

Behaviour:
- Reset:
  - state = INIT_LO; iocs = 0; iorw = 1; ioaddr = 00; databus high-Z.
  - last_rx = 0; echo_cnt = 0; cfg_pending = 0.
  - cfg_q is loaded with the synchronized br_cfg.
- Divisor select: DIV = table[cfg_q]; 16 bits, written as low byte then high byte.
- FSM, one state per cycle unless stated:
  - INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0]. Next: INIT_HI.
  - INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8]. Next: IDLE.
  - IDLE: iocs=0.
    - If cfg_pending: clear it, then go to INIT_LO. This takes priority over rda.
    - Else if rda=1: go to READ.
    - Else stay in IDLE.
  - READ: iocs=1, iorw=1, ioaddr=00. Sample databus into rx_byte and last_rx at the end of this cycle. Next: WAIT_TBR.
  - WAIT_TBR: iocs=0. Stay while tbr=0; when tbr=1 go to WRITE. There is no timeout.
  - WRITE: iocs=1, iorw=0, ioaddr=00, databus=rx_byte. Increment echo_cnt (modulo 256). Next: IDLE.
- Whenever iocs=0: iorw=1 and ioaddr=00. The block never drives databus in that case.
- Latency:
  - Reset release to DB high written: 2 cycles.
  - rda seen in IDLE to byte read: 1 cycle.
  - tbr seen in WAIT_TBR to byte written: 1 cycle.
  - Minimum echo: 3 cycles from IDLE with rda=1 and tbr=1.
- Reconfiguration:
  - When the synchronized br_cfg differs from cfg_q, set cfg_pending and load cfg_q in the same cycle.
  - The divisor reload happens only from IDLE. A change during READ, WAIT_TBR or WRITE never aborts the echo in flight; it is applied after the echo returns to IDLE.
  - Multiple changes before IDLE collapse into one reload using the latest value.
- rda asserted during INIT_LO or INIT_HI: ignored until IDLE, then serviced normally.
- rda must drop after the READ access (SPART behaviour). If rda is still 1 when the FSM returns to IDLE, the block starts another read; this is legal.
- rst asserted in any state, including mid-WRITE: on the next edge, databus is released and the FSM restarts at INIT_LO. The in-flight byte is discarded and is not counted.
- Single driver: databus enable = iocs & ~iorw, registered from state. There must be no cycle in which the block drives databus during a read.

Test Plan:
- Reset with br_cfg=11, hold rst 2 cycles, release:
  - Cycle 1: iocs=1, iorw=0, ioaddr=10, databus=0x50.
  - Cycle 2: ioaddr=11, databus=0x00.
  - Then idle with iocs=0 and databus=Z.
- br_cfg=01 at reset: DB writes are 0x45 then 0x01. Switch to 10 while idle: after synchronizer delay, writes 0xA2, 0x00 occur exactly once.
- Echo 0x88 with tbr=1: pulse rda and drive 0x88 on databus during READ.
  - WRITE follows 2 cycles after READ with databus=0x88.
  - last_rx=0x88; echo_cnt goes 0 -> 1.
- tbr=0 for 20 cycles after READ:
  - FSM holds in WAIT_TBR with iocs=0 throughout.
  - WRITE occurs the cycle after tbr rises.
  - No extra writes occur.
- br_cfg changes 11 -> 00 during WAIT_TBR:
  - The echo completes first.
  - Then 0x8A, 0x02 are written.
  - echo_cnt increments once.
- rst asserted in WRITE cycle:
  - Next cycle: databus=Z, echo_cnt=0, state INIT_LO.
  - After 255 -> 256 echoes in a separate run, echo_cnt wraps to 0.
